// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds, steps or redirects the fetch PC, resolves
// memory stalls and inserts one wrong-path bubble after every applied redirect.
//
// state | meaning
// BOOT  | single post-reset cycle, PC held, no fetch issued
// RUN   | fetch issued, PC steps or takes a decoded redirect
// STALL | memory busy, PC held, first redirect seen is parked in pending
// FLUSH | one wrong-path bubble after a redirect, decode inputs ignored
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4,
    parameter int          OFFSET_W     = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_jump,
    input  logic                i_branch_eq,
    input  logic                i_branch_ne,
    input  logic                i_zero,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic                i_imem_busy,
    input  logic                i_dmem_busy,
    output logic [31:0]         o_pc,
    output logic                o_pc_sel,
    output logic                o_fetch_valid,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_RUN   = 2'b01,
        S_STALL = 2'b10,
        S_FLUSH = 2'b11
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic        r_pend_valid;
    logic        r_pc_sel;
    logic        r_fetch_valid;

    logic        w_take;
    logic        w_stall;
    logic [31:0] w_off_ext;
    logic [31:0] w_off_bytes;
    logic [31:0] w_target;

    assign w_take      = i_jump | (i_branch_eq & i_zero) | (i_branch_ne & ~i_zero);
    assign w_stall     = i_imem_busy | i_dmem_busy;
    assign w_off_ext   = {{(32-OFFSET_W){i_offset[OFFSET_W-1]}}, i_offset};
    assign w_off_bytes = {w_off_ext[29:0], 2'b00};
    // Plain 32-bit sum: wrap-around is intentional and silent.
    assign w_target    = r_pc + PC_STEP + w_off_bytes;

    // Decode/stall inputs are only looked at inside the states that consume
    // them, so garbage on them during BOOT or FLUSH cannot reach the PC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_pend        <= 32'h0;
            r_pend_valid  <= 1'b0;
            r_pc_sel      <= 1'b0;
            r_fetch_valid <= 1'b0;
        end else begin
            r_pc_sel <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (w_stall) begin
                        r_state       <= S_STALL;
                        r_fetch_valid <= 1'b0;
                        if (w_take) begin
                            r_pend       <= w_target;
                            r_pend_valid <= 1'b1;
                        end
                    end else if (w_take) begin
                        r_pc          <= w_target;
                        r_pc_sel      <= 1'b1;
                        r_state       <= S_FLUSH;
                        r_fetch_valid <= 1'b0;
                    end else begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                S_STALL: begin
                    if (w_stall) begin
                        // Oldest redirect wins; younger decodes are wrong-path.
                        if (w_take && !r_pend_valid) begin
                            r_pend       <= w_target;
                            r_pend_valid <= 1'b1;
                        end
                    end else if (r_pend_valid) begin
                        r_pc          <= r_pend;
                        r_pc_sel      <= 1'b1;
                        r_pend_valid  <= 1'b0;
                        r_state       <= S_FLUSH;
                    end else begin
                        // PC held so the stalled fetch is reissued and re-decoded.
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (w_stall) begin
                        r_state <= S_STALL;
                    end else begin
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_sel      = r_pc_sel;
    assign o_fetch_valid = r_fetch_valid;
    assign o_state       = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, every cycle
// compared against a phase/queue reference model of the sequencing rules.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_jump = 1'b0;
    logic        i_branch_eq = 1'b0;
    logic        i_branch_ne = 1'b0;
    logic        i_zero = 1'b0;
    logic [7:0]  i_offset = 8'h00;
    logic        i_imem_busy = 1'b0;
    logic        i_dmem_busy = 1'b0;
    logic [31:0] o_pc;
    logic        o_pc_sel;
    logic        o_fetch_valid;
    logic [1:0]  o_state;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VECTOR(RV),
        .PC_STEP(32'd4),
        .OFFSET_W(8)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_jump(i_jump),
        .i_branch_eq(i_branch_eq),
        .i_branch_ne(i_branch_ne),
        .i_zero(i_zero),
        .i_offset(i_offset),
        .i_imem_busy(i_imem_busy),
        .i_dmem_busy(i_dmem_busy),
        .o_pc(o_pc),
        .o_pc_sel(o_pc_sel),
        .o_fetch_valid(o_fetch_valid),
        .o_state(o_state)
    );

    typedef enum {M_BOOT, M_RUN, M_STALL, M_FLUSH} mphase_t;
    mphase_t     m_phase = M_BOOT;
    logic [31:0] m_pc = RV;
    logic        m_sel = 1'b0;
    logic [31:0] m_pend[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] phase_code(input mphase_t p);
        case (p)
            M_BOOT:  return 2'b00;
            M_RUN:   return 2'b01;
            M_STALL: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // One clock: apply inputs, advance the model, then compare every output.
    task automatic step(input logic rst, input logic jmp, input logic beq, input logic bne,
                        input logic zf, input logic [7:0] off, input logic ib, input logic db);
        logic        take;
        logic        stall;
        int          soff;
        logic [31:0] tgt;
        i_reset = rst; i_jump = jmp; i_branch_eq = beq; i_branch_ne = bne;
        i_zero = zf; i_offset = off; i_imem_busy = ib; i_dmem_busy = db;
        @(posedge clk);
        take  = jmp | (beq & zf) | (bne & ~zf);
        stall = ib | db;
        soff  = int'($signed(off));
        tgt   = m_pc + 32'd4 + 32'(soff * 4);
        m_sel = 1'b0;
        if (rst) begin
            m_pc = RV;
            m_phase = M_BOOT;
            m_pend.delete();
        end else begin
            case (m_phase)
                M_BOOT: m_phase = M_RUN;
                M_RUN: begin
                    if (stall) begin
                        if (take) m_pend.push_back(tgt);
                        m_phase = M_STALL;
                    end else if (take) begin
                        m_pc = tgt; m_sel = 1'b1; m_phase = M_FLUSH;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end
                M_STALL: begin
                    if (stall) begin
                        if (take && m_pend.size() == 0) m_pend.push_back(tgt);
                    end else if (m_pend.size() != 0) begin
                        m_pc = m_pend.pop_front(); m_sel = 1'b1; m_phase = M_FLUSH;
                    end else begin
                        m_phase = M_RUN;
                    end
                end
                default: m_phase = stall ? M_STALL : M_RUN;
            endcase
        end
        #1;
        chk("pc", o_pc, m_pc);
        chk("pc_sel", {31'b0, o_pc_sel}, {31'b0, m_sel});
        chk("fetch_valid", {31'b0, o_fetch_valid}, {31'b0, (m_phase == M_RUN)});
        chk("state", {30'b0, o_state}, {30'b0, phase_code(m_phase)});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        // Reset held two cycles, then boot bubble and sequential fetch.
        step(1, 0, 0, 0, 0, 8'h00, 0, 0);
        step(1, 1, 0, 0, 0, 8'h33, 1, 0);
        chk("t1_reset_pc", o_pc, 32'h0);
        chk("t1_reset_state", {30'b0, o_state}, 32'd0);
        chk("t1_reset_fv", {31'b0, o_fetch_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 8'h10, 1, 1);
        chk("t1_pc0", o_pc, 32'h0);
        chk("t1_fv0", {31'b0, o_fetch_valid}, 32'd1);
        idle(1); chk("t1_pc4", o_pc, 32'h4);
        idle(1); chk("t1_pc8", o_pc, 32'h8);
        idle(2); chk("t2_pre", o_pc, 32'h10);

        // Backward jump, then one flush bubble.
        step(0, 1, 0, 0, 0, 8'hFE, 0, 0);
        chk("t2_pc", o_pc, 32'h0C);
        chk("t2_sel", {31'b0, o_pc_sel}, 32'd1);
        chk("t2_flush_fv", {31'b0, o_fetch_valid}, 32'd0);
        step(0, 1, 1, 1, 0, 8'h55, 0, 0);
        chk("t2_run_pc", o_pc, 32'h0C);
        chk("t2_run_state", {30'b0, o_state}, 32'd1);
        idle(5); chk("t3_pre", o_pc, 32'h20);

        // Conditional branches.
        step(0, 0, 1, 0, 0, 8'h03, 0, 0);
        chk("t3_beq_nt_pc", o_pc, 32'h24);
        chk("t3_beq_nt_sel", {31'b0, o_pc_sel}, 32'd0);
        step(0, 0, 1, 0, 1, 8'h02, 0, 0);
        chk("t3_beq_t_pc", o_pc, 32'h30);
        idle(1);
        step(0, 0, 0, 1, 1, 8'h03, 0, 0);
        chk("t3_bne_nt_pc", o_pc, 32'h34);
        step(0, 0, 0, 1, 0, 8'h02, 0, 0);
        chk("t3_bne_t_pc", o_pc, 32'h40);
        idle(1);

        // Stall at 0x40, first redirect wins.
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);
        chk("t4_pre", o_pc, 32'h44);
        step(0, 1, 0, 0, 0, 8'hFB, 0, 0);
        chk("t4_back", o_pc, 32'h34);
        idle(1);
        idle(3); chk("t4_at40", o_pc, 32'h40);
        step(0, 1, 0, 0, 0, 8'h04, 1, 0);
        step(0, 1, 0, 0, 0, 8'h09, 1, 0);
        step(0, 0, 0, 0, 0, 8'h00, 1, 0);
        chk("t4_hold_pc", o_pc, 32'h40);
        chk("t4_hold_state", {30'b0, o_state}, 32'd2);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);
        chk("t4_redir_pc", o_pc, 32'h54);
        chk("t4_redir_sel", {31'b0, o_pc_sel}, 32'd1);
        idle(1);

        // Wrap-around both ways.
        step(0, 1, 0, 0, 0, 8'hE9, 0, 0);
        chk("t5_top", o_pc, 32'hFFFF_FFFC);
        idle(2); chk("t5_wrap", o_pc, 32'h0);
        step(0, 1, 0, 0, 0, 8'h3F, 0, 0);
        idle(1); chk("t5_at100", o_pc, 32'h100);
        step(0, 1, 0, 0, 0, 8'h80, 0, 0);
        chk("t5_neg", o_pc, 32'hFFFF_FF04);
        idle(1);

        // Reset while a redirect is parked.
        step(0, 1, 0, 0, 0, 8'h05, 0, 1);
        chk("t6_stall", {30'b0, o_state}, 32'd2);
        step(1, 0, 0, 0, 0, 8'h00, 0, 1);
        chk("t6_rst_pc", o_pc, RV);
        step(0, 0, 0, 0, 0, 8'h00, 0, 0);
        idle(1);
        chk("t6_no_redir", o_pc, 32'h4);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(99) == 0),
                 ($urandom_range(7) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0),
                 1'($urandom_range(1)), 8'($urandom),
                 ($urandom_range(4) == 0), ($urandom_range(5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
